// File: rtl/lbp_scan_ctrl_if.sv
// Bus bundle between the LBP scan sequencer and its surroundings.
//   gray_*   : gray image memory read port (request/address out, data/ready in)
//   win_*    : assembled 3x3 window towards the combinational LBP core
//   lbp_code : combinational LBP result returned by the core
//   lbp_*    : result memory write port
//   finish   : image complete, sticky until reset
// master = sequencer side, slave = memories/core side.
interface lbp_scan_ctrl_if #(
  parameter int AW = 14
);
  logic          gray_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [7:0]    gray_data;
  logic          win_valid;
  logic [71:0]   win_data;
  logic [7:0]    lbp_code;
  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic [7:0]    lbp_data;
  logic          finish;

  modport master (
    input  gray_ready, gray_data, lbp_code,
    output gray_req, gray_addr, win_valid, win_data,
           lbp_valid, lbp_addr, lbp_data, finish
  );

  modport slave (
    output gray_ready, gray_data, lbp_code,
    input  gray_req, gray_addr, win_valid, win_data,
           lbp_valid, lbp_addr, lbp_data, finish
  );
endinterface

// File: rtl/lbp_scan_ctrl.sv
// Raster-scan sequencer for the LBP engine.
// Walks every interior pixel of an IMG_W x IMG_H gray image, fetches its 3x3
// neighbourhood (9 reads at a row start, then 3 reads per step, reusing two
// columns), hands the window to the LBP core and writes the code back.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : lbp_scan_ctrl_if master (gray read port, window, result write port, finish)
//
// state     | meaning
// ----------|-------------------------------------------------------------
// IDLE      | waiting for gray_ready to start the scan
// ROW_INIT  | issuing the 9 column-major reads of the first window in a row
// COL_FETCH | issuing the 3 reads of the new right-hand column
// CAPT      | no request; absorbs the byte of the last read
// WRITE     | window complete, win_valid high, lbp_code registered
// DONE      | image finished, finish held until reset
module lbp_scan_ctrl #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int AW    = 14
) (
  input logic             clk,
  input logic             reset,
  lbp_scan_ctrl_if.master bus
);
  localparam int CW = $clog2(IMG_W);

  typedef enum logic [2:0] {IDLE, ROW_INIT, COL_FETCH, CAPT, WRITE, DONE} state_t;

  state_t        state, state_n;
  logic [3:0]    idx, idx_n;
  logic [AW-1:0] row, row_n, col, col_n;
  logic          req, req_n;
  logic [AW-1:0] addr_q, addr_n;
  logic [3:0]    slot_q, slot_n;
  logic          pend;
  logic [3:0]    pend_slot;
  logic [71:0]   win_q;
  logic          shift, wr;
  logic [3:0]    last;
  logic [1:0]    rr, cc;
  logic [AW-1:0] fcol;
  logic          lbp_valid_q, finish_q;
  logic [AW-1:0] lbp_addr_q;
  logic [7:0]    lbp_data_q;

  // idx counts issued reads of the current fetch; it only advances in cycles
  // that actually carried a request, so a ready stall neither skips nor repeats.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    row_n   = row;
    col_n   = col;
    req_n   = 1'b0;
    shift   = 1'b0;
    wr      = 1'b0;
    last    = (state == ROW_INIT) ? 4'd8 : 4'd2;
    case (state)
      IDLE: begin
        if (bus.gray_ready) begin
          state_n = ROW_INIT;
          idx_n   = '0;
          req_n   = 1'b1;
        end
      end
      ROW_INIT, COL_FETCH: begin
        if (req && idx == last) begin
          state_n = CAPT;
        end else begin
          idx_n = idx + {3'b000, req};
          req_n = bus.gray_ready;
        end
      end
      CAPT: state_n = WRITE;
      WRITE: begin
        wr    = 1'b1;
        idx_n = '0;
        if (col < AW'(IMG_W - 2)) begin
          state_n = COL_FETCH;
          col_n   = col + AW'(1);
          shift   = 1'b1;
          req_n   = bus.gray_ready;
        end else if (row < AW'(IMG_H - 2)) begin
          state_n = ROW_INIT;
          row_n   = row + AW'(1);
          col_n   = AW'(1);
          req_n   = bus.gray_ready;
        end else begin
          state_n = DONE;
        end
      end
      DONE: state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  // Address and window slot of the read issued next cycle. ROW_INIT walks
  // column-major; COL_FETCH walks the new right column top to bottom.
  always_comb begin
    if (state_n == ROW_INIT) begin
      rr   = 2'(idx_n % 4'd3);
      cc   = 2'(idx_n / 4'd3);
      fcol = AW'(cc);
    end else begin
      rr   = idx_n[1:0];
      cc   = 2'd2;
      fcol = col_n + AW'(1);
    end
    addr_n = ((row_n + AW'(rr) - AW'(1)) << CW) + fcol;
    slot_n = 4'(rr) * 4'd3 + 4'(cc);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      row         <= AW'(1);
      col         <= AW'(1);
      req         <= 1'b0;
      addr_q      <= '0;
      slot_q      <= '0;
      pend        <= 1'b0;
      pend_slot   <= '0;
      win_q       <= '0;
      lbp_valid_q <= 1'b0;
      lbp_addr_q  <= '0;
      lbp_data_q  <= '0;
      finish_q    <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      row   <= row_n;
      col   <= col_n;
      req   <= req_n;
      if (req_n) begin
        addr_q <= addr_n;
        slot_q <= slot_n;
      end
      // read data arrives one cycle after the request cycle
      pend      <= req;
      pend_slot <= slot_q;
      if (shift) begin
        for (int i = 0; i < 3; i++) begin
          win_q[24*i +: 8]     <= win_q[24*i+8 +: 8];
          win_q[24*i+8 +: 8]   <= win_q[24*i+16 +: 8];
        end
      end
      if (pend) win_q[{pend_slot, 3'b000} +: 8] <= bus.gray_data;
      lbp_valid_q <= wr;
      if (wr) begin
        lbp_addr_q <= (row << CW) + col;
        lbp_data_q <= bus.lbp_code;
      end
      if (state_n == DONE) finish_q <= 1'b1;
    end
  end

  assign bus.gray_req  = req;
  assign bus.gray_addr = addr_q;
  assign bus.win_valid = (state == WRITE);
  assign bus.win_data  = win_q;
  assign bus.lbp_valid = lbp_valid_q;
  assign bus.lbp_addr  = lbp_addr_q;
  assign bus.lbp_data  = lbp_data_q;
  assign bus.finish    = finish_q;
endmodule
